// File: rtl/mem_pkg.sv
// mem_pkg: shared word width, address width and word type for the processor datapath
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/mem.sv
// mem: unified word-addressed memory, async read, sync write, async clear on rst_n
module mem #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);
  import mem_pkg::*;
  localparam int IW = $clog2(DEPTH);
  logic [DATA_W-1:0] m [DEPTH];
  logic [IW-1:0] idx;
  assign idx = a[IW-1:0];
  assign rd = m[idx];
  // upper address bits alias onto the stored words and are deliberately dropped
  generate
    if (IW < ADDR_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^a[ADDR_W-1:IW];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) m[i] <= '0;
    else if (we)
      m[idx] <= wd;
endmodule

// File: tb/tb_mem.sv
// tb_mem: directed self-checking bench for mem
module tb_mem;
  logic clk = 1'b0, rst_n = 1'b1, we = 1'b0;
  logic [15:0] a = '0, wd = '0, rd;
  int checks = 0, errors = 0;

  mem dut (.clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .rd(rd));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    a = addr; wd = data; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    a = addr;
    #1 chk(tag, rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0; a = 16'd10; we = 1'b0;
    #1 chk("rst_rd", rd, 16'h0000);
    #1 rst_n = 1'b1;
    #1 chk("rst_release", rd, 16'h0000);
    wr(16'd25, 16'habcd);
    chk("wr25", rd, 16'habcd);
    rdchk("rd5", 16'd5, 16'h0000);
    rdchk("rd25", 16'd25, 16'habcd);
    wd = 16'h1111;
    repeat (3) @(posedge clk);
    #1 chk("we_off", rd, 16'habcd);
    wr(16'd259, 16'h1234);
    rdchk("alias3", 16'd3, 16'h1234);
    rdchk("alias259", 16'd259, 16'h1234);
    rdchk("alias25_intact", 16'd25, 16'habcd);
    wr(16'd255, 16'hbeef);
    rdchk("top_word", 16'd255, 16'hbeef);
    rdchk("top_alias", 16'hffff, 16'hbeef);
    rdchk("rd0_clean", 16'd0, 16'h0000);
    @(negedge clk);
    a = 16'd40; wd = 16'h5a5a; we = 1'b1;
    #1 chk("rdw_before", rd, 16'h0000);
    @(posedge clk);
    #1 chk("rdw_after", rd, 16'h5a5a);
    we = 1'b0;
    @(negedge clk);
    a = 16'd25; wd = 16'hffff; we = 1'b1;
    #1 chk("pre_rst", rd, 16'habcd);
    rst_n = 1'b0;
    #1 chk("rst_async", rd, 16'h0000);
    @(posedge clk);
    #1 chk("rst_dominates", rd, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_no_write", rd, 16'h0000);
    we = 1'b0;
    rdchk("post_rst25", 16'd25, 16'h0000);
    rdchk("post_rst3", 16'd3, 16'h0000);
    rdchk("post_rst40", 16'd40, 16'h0000);
    rdchk("post_rst255", 16'd255, 16'h0000);
    wr(16'd40, 16'h0f0f);
    chk("post_rst_wr", rd, 16'h0f0f);
    rdchk("post_rst_other", 16'd25, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem.md
Name: mem

Overview:
- Unified instruction/data memory for the 16-bit multicycle processor.
- One read/write port, word-addressed.
- Combinational (asynchronous) read; synchronous write on the rising clock edge.
- Asynchronous active-low reset clears the entire array.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 16, address bus width in bits.
- DEPTH, 256, number of words stored; must be a power of two, with DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable, sampled on the rising edge of clk.
- a  input  ADDR_W  word address, shared by read and write.
- wd  input  DATA_W  write data.
- rd  output  DATA_W  read data for the word at address a.

Behaviour:
- One clock; reset is asynchronous and active-low.
  - Clock port is clk; reset port is rst_n.
  - Asserting rst_n low immediately clears all DEPTH words to 0, independent of clk.
  - The array stays cleared while rst_n is low.
- Reset values:
  - rd = 0 while in reset, since every word is 0.
  - No other state exists.
- Indexing:
  - Word index = a[log2(DEPTH)-1:0].
  - Upper address bits are ignored, so addresses alias modulo DEPTH (e.g. a=259 maps to word 3).
- Read:
  - Purely combinational: rd = array[index(a)].
  - Zero-cycle latency; rd follows changes on a within the same delta/cycle.
  - No read enable.
- Write:
  - On posedge clk with rst_n high and we=1: array[index(a)] <= wd.
  - With we=0 the array is unchanged.
  - No byte enables; always a full word.
- Read-during-write, same address:
  - Before the edge, rd shows the old contents.
  - After the edge, rd shows wd, combinationally, in the same cycle after the edge.
- Reset versus write:
  - Reset dominates.
  - If rst_n is low at a clock edge with we=1, no write occurs and the array stays zero.
  - Deasserting rst_n does not itself cause a write; the first write happens on the next qualified edge.
- X handling:
  - If we is 1 at an edge, the write is performed even if wd carries X.
  - Address X is not required to be handled.
- No handshake, no wait states. Every access completes in one cycle.

Decomposition:
- Package mem_pkg holds:
  - localparams DATA_W=16 and ADDR_W=16.
  - A word typedef, logic [DATA_W-1:0], shared with the datapath and register file.
- The block is a single module with no sub-modules.
- Parameters default from mem_pkg.

Test Plan:
- Reset and default reads:
  - Stimulus: pulse rst_n low between edges, release, we=0, a=10.
  - Required: rd=16'h0000 immediately, with no clock edge needed.
- Basic write/read:
  - Stimulus: a=25, we=1, wd=16'habcd for one edge, then we=0.
  - Required: rd=16'habcd after the edge; a=5 then gives rd=16'h0000; a=25 again gives rd=16'habcd.
- Write disabled:
  - Stimulus: we=0, wd=16'h1111, a=25 across several edges.
  - Required: rd stays 16'habcd.
- Address aliasing:
  - Stimulus: write 16'h1234 at a=259.
  - Required: reading a=3 gives rd=16'h1234; reading a=259 gives the same value.
- Read-during-write:
  - Stimulus: a=40 holding 16'h0000, we=1, wd=16'h5a5a.
  - Required: rd=16'h0000 before the edge and 16'h5a5a right after it.
- Reset mid-operation:
  - Stimulus: after the above writes, assert rst_n low asynchronously while we=1, wd=16'hffff, a=25, spanning a clock edge.
  - Required: rd=16'h0000 immediately; after release, reads at 25, 3 and 40 all return 16'h0000.
